// File: rtl/fft_pkg.sv
// Shared constants for the FFT frame routing blocks: default sample width,
// default frame length and the A/B select polarity shared with the merge mux.
package fft_pkg;

  localparam int SAMPLE_W      = 16;
  localparam int FRAME_LEN_DEF = 256;

  localparam logic ROUTE_A = 1'b1;
  localparam logic ROUTE_B = 1'b0;

  // State encoding equals the route bit, so the state register drives route directly.
  typedef enum logic {
    RUN_B = 1'b0,
    RUN_A = 1'b1
  } route_state_t;

endpackage

// File: rtl/fft_out_reg.sv
// Single-entry valid/ready output stage carrying data plus a last flag.
// Loads on i_load; otherwise empties when the consumer takes the entry.
module fft_out_reg #(
  parameter int WIDTH = fft_pkg::SAMPLE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_last;

  // The upstream only asserts i_load when the entry is empty or draining this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

// File: rtl/fft_frame_demux.sv
// 1:2 frame router: steers whole FRAME_LEN-sample frames to port A or B (ping-pong or forced).
// Define FFT_DEMUX_LAST_CHECK_EN to add s_last and a sticky frame_err check.
module fft_frame_demux
  import fft_pkg::*;
#(
  parameter int WIDTH     = SAMPLE_W,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             mode,
  input  logic             force_sel,
  output logic             m_a_valid,
  input  logic             m_a_ready,
  output logic [WIDTH-1:0] m_a_data,
  output logic             m_a_last,
  output logic             m_b_valid,
  input  logic             m_b_ready,
  output logic [WIDTH-1:0] m_b_data,
  output logic             m_b_last,
  output logic             route,
  output logic             frame_err
`ifdef FFT_DEMUX_LAST_CHECK_EN
  ,
  input  logic             s_last
`endif
);

  route_state_t     r_state;
  route_state_t     w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  // Lane index follows the route polarity: lane 1 is port A, lane 0 is port B.
  logic             w_valid [2];
  logic             w_ready [2];
  logic [WIDTH-1:0] w_data  [2];
  logic             w_last  [2];
  logic             w_load  [2];

  logic w_fire;
  logic w_at_end;

  assign w_ready[ROUTE_A] = m_a_ready;
  assign w_ready[ROUTE_B] = m_b_ready;

  assign w_at_end = (r_cnt == CNT_W'(FRAME_LEN - 1));
  assign s_ready  = !rst && (!w_valid[r_state] || w_ready[r_state]);
  assign w_fire   = s_valid && s_ready;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign w_load[gi] = w_fire && (r_state == route_state_t'(gi));

      fft_out_reg #(
        .WIDTH(WIDTH)
      ) u_out_reg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load[gi]),
        .i_data (s_data),
        .i_last (w_at_end),
        .i_ready(w_ready[gi]),
        .o_valid(w_valid[gi]),
        .o_data (w_data[gi]),
        .o_last (w_last[gi])
      );
    end
  endgenerate

  assign m_a_valid = w_valid[ROUTE_A];
  assign m_a_data  = w_data[ROUTE_A];
  assign m_a_last  = w_last[ROUTE_A];
  assign m_b_valid = w_valid[ROUTE_B];
  assign m_b_data  = w_data[ROUTE_B];
  assign m_b_last  = w_last[ROUTE_B];
  assign route     = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN_A;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Route is re-decided only on the transfer that closes a frame.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (w_fire) begin
      if (w_at_end) begin
        w_cnt_next = '0;
        if (mode) begin
          w_state_next = force_sel ? RUN_A : RUN_B;
        end else begin
          w_state_next = (r_state == RUN_A) ? RUN_B : RUN_A;
        end
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

`ifdef FFT_DEMUX_LAST_CHECK_EN
  logic r_frame_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_err <= 1'b0;
    end else if (w_fire && (s_last != w_at_end)) begin
      r_frame_err <= 1'b1;
    end
  end

  assign frame_err = r_frame_err;
`else
  assign frame_err = 1'b0;
`endif

endmodule
